mem_io_sequencer: RTL and testbench
===================================

// Module: mem_io_sequencer
// PURPOSE
//  Owns the single data port (a2/wd/we/rd2) of the segmented data memory and shares it between
//  the CPU and a byte-wide host link. Sequences a full image job: LOAD host pixels into the input
//  segment, RUN the CPU (drives startIO), catch the CPU "done" write, DUMP the output segment to host.
//  Sits between the core's data-memory port and the memory top; CPU sees memory only while RUN.
// PARAMETERS
//  WIDTH      24      data/address width of memory port
//  IN_BASE    302     first address of input-pixel segment
//  OUT_BASE   90302   first address of output-pixel segment
//  NPIX       90000   pixels per image (both segments)
//  DONE_ADDR  180303  CPU-write-only completion register, decoded here, never forwarded
// PORTS
//  clk        in   1      clock
//  reset      in   1      synchronous, active-high reset
//  start      in   1      host job request (level sampled each cycle)
//  host_valid in   1      host input byte valid
//  host_data  in   8      input pixel byte
//  host_ready out  1      sequencer accepts host byte
//  out_valid  out  1      output pixel byte valid
//  out_data   out  8      output pixel byte
//  out_ready  in   1      host accepts output byte
//  cpu_we     in   1      CPU data write enable
//  cpu_a      in   WIDTH  CPU data address
//  cpu_wd     in   WIDTH  CPU write data
//  cpu_rd     out  WIDTH  CPU read data
//  mem_we     out  1      to memory we
//  mem_a      out  WIDTH  to memory a2
//  mem_wd     out  WIDTH  to memory wd
//  mem_rd     in   WIDTH  from memory rd2 (combinational read, same cycle as mem_a)
//  start_io   out  1      to memory startIO; 1 only in RUN
//  busy       out  1      1 in LOAD/RUN/DUMP_RD/DUMP_WAIT
//  done       out  1      1 in DONE
// BEHAVIOUR
//  - Reset: state=IDLE, idx=0, all outputs 0 (host_ready, out_valid, out_data, start_io, busy, done,
//    mem_we, mem_a, mem_wd, cpu_rd). Reset mid-job aborts immediately; memory contents untouched.
//  - idx: unsigned $clog2(NPIX) bits; cleared on every state entry; addresses = base + zero-ext idx.
//  - IDLE: start=1 -> LOAD next cycle. DONE: start=1 -> LOAD (new job); else hold. start ignored elsewhere.
//  - LOAD: host_ready=1. Beat = host_valid&host_ready: same cycle mem_we=1, mem_a=IN_BASE+idx,
//    mem_wd={16'b0,host_data}; idx++. Beat with idx==NPIX-1 -> RUN. No beat: mem_we=0.
//  - RUN: start_io=1; mem_we/mem_a/mem_wd = cpu_we/cpu_a/cpu_wd, cpu_rd=mem_rd, except cpu_a==DONE_ADDR:
//    mem_we forced 0, cpu_rd=0; if cpu_we & cpu_wd[0] -> DUMP_RD next cycle (cpu_wd[0]=0 ignored).
//  - Outside RUN: CPU writes dropped (mem_we from CPU never reaches memory), cpu_rd=0, start_io=0.
//  - DUMP_RD: mem_a=OUT_BASE+idx, mem_we=0; out_data<=mem_rd[7:0] registered; -> DUMP_WAIT.
//  - DUMP_WAIT: out_valid=1, out_data stable until out_ready. On out_ready: idx==NPIX-1 -> DONE,
//    else idx++ and -> DUMP_RD. Throughput 1 byte / 2 cycles max; out_valid never drops without ready.
//  - host_valid outside LOAD ignored (host_ready=0). out_ready outside DUMP_WAIT ignored.
//  - mem_a=0, mem_wd=0 in IDLE/DONE/DUMP_WAIT.
// TESTING (bench overrides NPIX=4, IN_BASE=302, OUT_BASE=90302)
//  1 reset, start=1, 4 host beats 0x11..0x44 -> writes at 302..305 wd=0x000011..0x000044, then start_io=1.
//  2 LOAD with host_valid gaps (1,0,0,1,...) -> idx advances only on beats; exactly 4 writes, no extras.
//  3 RUN: CPU reads 302 -> cpu_rd=0x000011; CPU writes 90302..90305; CPU write DONE_ADDR wd=0 -> stays RUN,
//    mem_we=0 that cycle; wd=1 -> DUMP_RD, start_io=0 next cycle.
//  4 DUMP with out_ready stalled 3 cycles on byte 2 -> out_data held, 4 bytes in order, then done=1.
//  5 reset asserted in LOAD after 2 beats -> IDLE next cycle, all outputs 0; new start restarts at addr 302.
//  6 CPU writes during LOAD/DUMP -> mem_we never driven by CPU, cpu_rd=0; start in DONE -> new LOAD.

Source files
------------

// File: rtl/mem_io_sequencer_if.sv
// Bundle of the host byte links, the CPU data port and the memory data port
// that the sequencer arbitrates. The master side is the sequencer itself.
interface mem_io_sequencer_if #(
    parameter int WIDTH = 24
);
    // host input byte stream
    logic             host_valid;
    logic [7:0]       host_data;
    logic             host_ready;
    // host output byte stream
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_ready;
    // CPU data port
    logic             cpu_we;
    logic [WIDTH-1:0] cpu_a;
    logic [WIDTH-1:0] cpu_wd;
    logic [WIDTH-1:0] cpu_rd;
    // memory data port
    logic             mem_we;
    logic [WIDTH-1:0] mem_a;
    logic [WIDTH-1:0] mem_wd;
    logic [WIDTH-1:0] mem_rd;

    modport master (
        input  host_valid, host_data, out_ready,
        input  cpu_we, cpu_a, cpu_wd, mem_rd,
        output host_ready, out_valid, out_data,
        output cpu_rd, mem_we, mem_a, mem_wd
    );

    modport slave (
        output host_valid, host_data, out_ready,
        output cpu_we, cpu_a, cpu_wd, mem_rd,
        input  host_ready, out_valid, out_data,
        input  cpu_rd, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/mem_io_sequencer.sv
// Shares the single data-memory port between a byte-wide host link and the
// CPU. A job loads the input segment from the host, lets the CPU run until it
// writes 1 to the completion register, then streams the output segment back.
module mem_io_sequencer #(
    parameter int WIDTH     = 24,
    parameter int IN_BASE   = 302,
    parameter int OUT_BASE  = 90302,
    parameter int NPIX      = 90000,
    parameter int DONE_ADDR = 180303
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    mem_io_sequencer_if.master bus,
    output logic               start_io,
    output logic               busy,
    output logic               done
);
    localparam int               IDX_W      = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NPIX - 1);
    localparam logic [WIDTH-1:0] IN_BASE_W  = WIDTH'(IN_BASE);
    localparam logic [WIDTH-1:0] OUT_BASE_W = WIDTH'(OUT_BASE);
    localparam logic [WIDTH-1:0] DONE_A_W   = WIDTH'(DONE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DUMP_RD,
        S_DUMP_WAIT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       out_data_q;
    logic             host_ready_q;
    logic             out_valid_q;
    logic             start_io_q;
    logic             busy_q;
    logic             done_q;

    logic             load_beat;
    logic             cpu_done_hit;
    logic             done_trigger;
    logic [WIDTH-1:0] idx_ext;

    assign idx_ext      = WIDTH'(idx_q);
    assign load_beat    = (state_q == S_LOAD) && bus.host_valid;
    assign cpu_done_hit = (bus.cpu_a == DONE_A_W);
    assign done_trigger = (state_q == S_RUN) && cpu_done_hit && bus.cpu_we && bus.cpu_wd[0];

    // Next-state and pixel index. idx restarts at 0 whenever a new phase
    // (LOAD, RUN, DUMP, DONE) begins; within the dump loop it carries across
    // the DUMP_RD/DUMP_WAIT pair so each pass fetches the next pixel.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                if (load_beat) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_RUN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_RUN: begin
                if (done_trigger) begin
                    state_d = S_DUMP_RD;
                    idx_d   = '0;
                end
            end
            S_DUMP_RD: begin
                state_d = S_DUMP_WAIT;
            end
            S_DUMP_WAIT: begin
                if (bus.out_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                        idx_d   = '0;
                    end else begin
                        state_d = S_DUMP_RD;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State register with status outputs decoded from the next state, so
    // every handshake/status flag leaves the block straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            out_data_q   <= '0;
            host_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            start_io_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            host_ready_q <= (state_d == S_LOAD);
            out_valid_q  <= (state_d == S_DUMP_WAIT);
            start_io_q   <= (state_d == S_RUN);
            busy_q       <= (state_d == S_LOAD) || (state_d == S_RUN) ||
                            (state_d == S_DUMP_RD) || (state_d == S_DUMP_WAIT);
            done_q       <= (state_d == S_DONE);
            if (state_q == S_DUMP_RD) begin
                out_data_q <= bus.mem_rd[7:0];
            end
        end
    end

    // Memory port mux: host writes in LOAD, CPU pass-through in RUN (with the
    // completion register swallowed), output-segment fetch in DUMP_RD.
    always_comb begin
        bus.mem_we = 1'b0;
        bus.mem_a  = '0;
        bus.mem_wd = '0;
        bus.cpu_rd = '0;
        case (state_q)
            S_LOAD: begin
                bus.mem_we = load_beat;
                bus.mem_a  = IN_BASE_W + idx_ext;
                bus.mem_wd = WIDTH'(bus.host_data);
            end
            S_RUN: begin
                bus.mem_we = bus.cpu_we && !cpu_done_hit;
                bus.mem_a  = bus.cpu_a;
                bus.mem_wd = bus.cpu_wd;
                bus.cpu_rd = cpu_done_hit ? '0 : bus.mem_rd;
            end
            S_DUMP_RD: begin
                bus.mem_a = OUT_BASE_W + idx_ext;
            end
            default: begin
                bus.mem_we = 1'b0;
            end
        endcase
    end

    assign bus.host_ready = host_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign start_io       = start_io_q;
    assign busy           = busy_q;
    assign done           = done_q;
endmodule

// File: tb/tb_mem_io_sequencer.sv
// Directed bench for mem_io_sequencer with NPIX=4. A small word memory sits on
// the memory port; a scoreboard of expected memory writes and expected output
// bytes is checked every cycle, along with handshake and gating rules.
module tb_mem_io_sequencer;
    localparam int W    = 24;
    localparam int DONE = 180303;

    logic clk;
    logic reset;
    logic start;
    logic start_io;
    logic busy;
    logic done;

    int total = 0;
    int bad   = 0;

    mem_io_sequencer_if #(.WIDTH(W)) bus ();

    mem_io_sequencer #(
        .WIDTH(W), .IN_BASE(302), .OUT_BASE(90302), .NPIX(4), .DONE_ADDR(DONE)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .start_io(start_io), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory covering the input segment (slots 0..3), output segment
    // (slots 4..7) and one catch-all slot for any other address.
    logic [W-1:0] mem [0:8];

    function automatic int slot(logic [W-1:0] a);
        if (a >= 24'd302 && a < 24'd306) return int'(a) - 302;
        if (a >= 24'd90302 && a < 24'd90306) return int'(a) - 90302 + 4;
        return 8;
    endfunction

    always_comb bus.mem_rd = mem[slot(bus.mem_a)];

    always @(posedge clk) begin
        if (bus.mem_we) mem[slot(bus.mem_a)] <= bus.mem_wd;
    end

    // Scoreboard contents
    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] d;
    } wr_t;

    wr_t        wq[$];
    logic [7:0] oq[$];
    wr_t        we_exp;
    logic [7:0] ob_exp;
    logic       prev_valid;
    logic       prev_ready;
    logic [7:0] prev_data;

    // Per-cycle compare against the scoreboard and the handshake rules
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_data  = 8'h00;
        end else begin
            if (bus.mem_we) begin
                total++;
                if (wq.size() == 0) begin
                    bad++;
                    $display("FAIL extra_write: got a=%0d wd=%h, required no write", bus.mem_a, bus.mem_wd);
                end else begin
                    we_exp = wq.pop_front();
                    if (bus.mem_a !== we_exp.a || bus.mem_wd !== we_exp.d) begin
                        bad++;
                        $display("FAIL mem_write: got a=%0d wd=%h, required a=%0d wd=%h",
                                 bus.mem_a, bus.mem_wd, we_exp.a, we_exp.d);
                    end else begin
                        $display("write a=%0d wd=%h", bus.mem_a, bus.mem_wd);
                    end
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (oq.size() == 0) begin
                    bad++;
                    $display("FAIL extra_byte: got %h, required no byte", bus.out_data);
                end else begin
                    ob_exp = oq.pop_front();
                    if (bus.out_data !== ob_exp) begin
                        bad++;
                        $display("FAIL out_byte: got %h, required %h", bus.out_data, ob_exp);
                    end else begin
                        $display("byte out %h", bus.out_data);
                    end
                end
            end
            if (prev_valid && !prev_ready) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin
                    bad++;
                    $display("FAIL out_hold: got valid=%b data=%h, required valid=1 data=%h",
                             bus.out_valid, bus.out_data, prev_data);
                end
            end
            if (!start_io) begin
                total++;
                if (bus.cpu_rd !== '0) begin
                    bad++;
                    $display("FAIL cpu_rd_gate: got %h, required 0", bus.cpu_rd);
                end
            end
            total++;
            if (busy && done) begin
                bad++;
                $display("FAIL busy_done: got busy=1 done=1, required not both");
            end
            prev_valid = bus.out_valid;
            prev_ready = bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic at_sample();
        #3;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_host_ready"}, 32'(bus.host_ready), 0);
        chk({tag, "_out_valid"},  32'(bus.out_valid), 0);
        chk({tag, "_out_data"},   32'(bus.out_data), 0);
        chk({tag, "_start_io"},   32'(start_io), 0);
        chk({tag, "_busy"},       32'(busy), 0);
        chk({tag, "_done"},       32'(done), 0);
        chk({tag, "_mem_we"},     32'(bus.mem_we), 0);
        chk({tag, "_mem_a"},      32'(bus.mem_a), 0);
        chk({tag, "_mem_wd"},     32'(bus.mem_wd), 0);
        chk({tag, "_cpu_rd"},     32'(bus.cpu_rd), 0);
    endtask

    function automatic wr_t mk(input logic [W-1:0] a, input logic [W-1:0] d);
        wr_t r;
        r.a = a;
        r.d = d;
        return r;
    endfunction

    logic [7:0] bytes_a [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] bytes_c [4] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    logic [W-1:0] cpu_vals [4] = '{24'hABCD5A, 24'h00006B, 24'h00007C, 24'hFFFF8D};
    logic [7:0] dump_exp [4] = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        bus.host_valid = 1'b0;
        bus.host_data  = 8'h00;
        bus.out_ready  = 1'b0;
        bus.cpu_we     = 1'b0;
        bus.cpu_a      = '0;
        bus.cpu_wd     = '0;

        // Reset state
        tick();
        tick();
        at_sample();
        check_all_zero("reset");
        tick();
        reset = 1'b0;

        // Job A: contiguous load
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("load_host_ready", 32'(bus.host_ready), 1);
        chk("load_busy", 32'(busy), 1);
        for (int k = 0; k < 4; k++) wq.push_back(mk(24'(302 + k), 24'(bytes_a[k])));
        for (int k = 0; k < 4; k++) begin
            bus.host_valid = 1'b1;
            bus.host_data  = bytes_a[k];
            tick();
        end
        bus.host_valid = 1'b0;
        at_sample();
        chk("run_start_io", 32'(start_io), 1);
        chk("run_host_ready", 32'(bus.host_ready), 0);

        // RUN: CPU reads back the first input pixel
        tick();
        bus.cpu_a = 24'd302;
        at_sample();
        chk("cpu_read_302", 32'(bus.cpu_rd), 32'h000011);

        // RUN: CPU fills the output segment
        for (int k = 0; k < 4; k++) wq.push_back(mk(24'(90302 + k), cpu_vals[k]));
        for (int k = 0; k < 4; k++) begin
            tick();
            bus.cpu_we = 1'b1;
            bus.cpu_a  = 24'(90302 + k);
            bus.cpu_wd = cpu_vals[k];
        end
        tick();
        bus.cpu_a  = 24'(DONE);
        bus.cpu_wd = 24'd0;
        at_sample();
        chk("done_wd0_mem_we", 32'(bus.mem_we), 0);
        chk("done_wd0_cpu_rd", 32'(bus.cpu_rd), 0);
        tick();
        at_sample();
        chk("done_wd0_stays_run", 32'(start_io), 1);
        tick();
        bus.cpu_wd = 24'd1;
        tick();
        // CPU keeps writing the output segment during DUMP; it must not land
        bus.cpu_a  = 24'd90302;
        bus.cpu_wd = 24'hFFFFFF;
        at_sample();
        chk("dump_start_io", 32'(start_io), 0);
        chk("dump_busy", 32'(busy), 1);

        // DUMP with a 3-cycle stall on byte index 1
        for (int k = 0; k < 4; k++) oq.push_back(dump_exp[k]);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!bus.out_valid && n < 10) begin
                tick();
                n++;
            end
            chk("dump_valid_seen", 32'(bus.out_valid), 1);
            chk("dump_byte", 32'(bus.out_data), 32'(dump_exp[k]));
            if (k == 1) begin
                repeat (3) tick();
                chk("dump_byte_held", 32'(bus.out_data), 32'(dump_exp[k]));
            end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
        bus.cpu_we = 1'b0;
        at_sample();
        chk("jobA_done", 32'(done), 1);
        chk("jobA_busy", 32'(busy), 0);
        chk("jobA_out_valid", 32'(bus.out_valid), 0);

        // Job B: start from DONE, gapped load with stray CPU writes, then reset
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("jobB_host_ready", 32'(bus.host_ready), 1);
        chk("jobB_done_clear", 32'(done), 0);
        bus.cpu_we = 1'b1;
        bus.cpu_a  = 24'd302;
        bus.cpu_wd = 24'h777777;
        wq.push_back(mk(24'd302, 24'h0000A1));
        wq.push_back(mk(24'd303, 24'h0000B2));
        bus.host_valid = 1'b1;
        bus.host_data  = 8'hA1;
        tick();
        bus.host_valid = 1'b0;
        bus.host_data  = 8'hEE;
        at_sample();
        chk("gap_mem_we", 32'(bus.mem_we), 0);
        chk("gap_host_ready", 32'(bus.host_ready), 1);
        tick();
        tick();
        bus.host_valid = 1'b1;
        bus.host_data  = 8'hB2;
        tick();
        bus.host_valid = 1'b0;
        reset = 1'b1;
        tick();
        at_sample();
        check_all_zero("midload_reset");
        tick();
        reset = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_a  = '0;
        bus.cpu_wd = '0;

        // Job C: restart from address 302, then a full-speed dump
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) wq.push_back(mk(24'(302 + k), 24'(bytes_c[k])));
        for (int k = 0; k < 4; k++) begin
            bus.host_valid = 1'b1;
            bus.host_data  = bytes_c[k];
            tick();
        end
        bus.host_valid = 1'b0;
        chk("jobC_run", 32'(start_io), 1);
        bus.cpu_we = 1'b1;
        bus.cpu_a  = 24'(DONE);
        bus.cpu_wd = 24'd1;
        tick();
        bus.cpu_we    = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) oq.push_back(dump_exp[k]);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        bus.out_ready = 1'b0;
        chk("jobC_done", 32'(done), 1);
        chk("jobC_dump_cycles", 32'(n), 8);

        tick();
        chk("writes_drained", 32'(wq.size()), 0);
        chk("bytes_drained", 32'(oq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
